// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: NOP word and fetch-stage state encodings.
package rv32i_pkg;

    localparam int unsigned INSTR_W = 32;

    // ADDI x0,x0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'b00,
        FETCH_REQ   = 2'b01,
        FETCH_WAIT  = 2'b10,
        FETCH_VALID = 2'b11
    } fetch_state_e;

endpackage : rv32i_pkg

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC register and decode.
// Issues one word read per PC on a req/gnt/rvalid bus (one outstanding) and
// holds the returned word for decode under a valid/ready handshake.
// Optional build macro IFETCH_MISALIGN_CHECK_EN: a misaligned PC skips the bus
// and presents NOP_INSTR with fetch_err set.
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc_i,
    input  logic                fetch_en,
    input  logic                flush,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_err,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                fetch_err,
    output logic                pc_advance
);

    fetch_state_e           r_state;
    fetch_state_e           w_next_state;

    logic [ADDR_W-1:0]      r_addr_q;
    logic [ADDR_W-1:0]      w_addr_q;
    logic                   r_drop;
    logic                   w_drop;
    logic                   r_imem_req;
    logic                   w_imem_req;
    logic [ADDR_W-1:0]      r_imem_addr;
    logic [ADDR_W-1:0]      w_imem_addr;
    logic                   r_instr_valid;
    logic                   w_instr_valid;
    logic [INSTR_W-1:0]     r_instr;
    logic [INSTR_W-1:0]     w_instr;
    logic [ADDR_W-1:0]      r_instr_pc;
    logic [ADDR_W-1:0]      w_instr_pc;
    logic                   r_fetch_err;
    logic                   w_fetch_err;

    logic                   w_start;
    logic                   w_misalign;

    // A new fetch may only begin when enabled and not being redirected.
    assign w_start = fetch_en & ~flush;

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Non-word-aligned PC is reported instead of fetched.
    assign w_misalign = (pc_i[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: flush only ends a transaction at a point the bus allows.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FETCH_IDLE: begin
                if (w_start) begin
                    w_next_state = w_misalign ? FETCH_VALID : FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (imem_gnt) begin
                    w_next_state = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    w_next_state = (r_drop || flush) ? FETCH_IDLE : FETCH_VALID;
                end
            end
            FETCH_VALID: begin
                if (flush || instr_ready) begin
                    w_next_state = FETCH_IDLE;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
            end
        endcase
    end

    // Output/datapath logic: next values for every registered output.
    always_comb begin
        w_addr_q      = r_addr_q;
        w_drop        = r_drop;
        w_imem_addr   = r_imem_addr;
        w_instr       = r_instr;
        w_instr_pc    = r_instr_pc;
        w_fetch_err   = r_fetch_err;
        w_imem_req    = (w_next_state == FETCH_REQ);
        w_instr_valid = (w_next_state == FETCH_VALID);
        case (r_state)
            FETCH_IDLE: begin
                if (w_start) begin
                    w_addr_q = pc_i;
                    if (w_misalign) begin
                        w_instr     = NOP_INSTR;
                        w_instr_pc  = pc_i;
                        w_fetch_err = 1'b1;
                    end else begin
                        w_imem_addr = {pc_i[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            FETCH_REQ: begin
                // Request cannot be withdrawn; remember to discard its response.
                if (flush) begin
                    w_drop = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (imem_rvalid) begin
                    if (r_drop || flush) begin
                        w_drop = 1'b0;
                    end else begin
                        w_instr     = imem_rdata;
                        w_instr_pc  = r_addr_q;
                        w_fetch_err = imem_err;
                    end
                end else if (flush) begin
                    w_drop = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_q      <= '0;
            r_drop        <= 1'b0;
            r_imem_req    <= 1'b0;
            r_imem_addr   <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_addr_q      <= w_addr_q;
            r_drop        <= w_drop;
            r_imem_req    <= w_imem_req;
            r_imem_addr   <= w_imem_addr;
            r_instr_valid <= w_instr_valid;
            r_instr       <= w_instr;
            r_instr_pc    <= w_instr_pc;
            r_fetch_err   <= w_fetch_err;
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign fetch_err   = r_fetch_err;

    // Core loads next_pc on a real (non-flushed) acceptance.
    assign pc_advance  = r_instr_valid & instr_ready & ~flush;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: bus/core models drive the DUT; expected words are
// queued when the bus answers a live fetch and checked by a separate monitor.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        fetch_en;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;
    logic        pc_advance;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_err    (imem_err),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .fetch_err   (fetch_err),
        .pc_advance  (pc_advance)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          adv_count = 0;
    int          retired = 0;
    logic        adv_flag = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] tx_addr_exp = '0;
    logic [31:0] pc_at_edge = '0;

    // Bus model state
    int          bus_phase = 0;
    int          gnt_cnt = 0;
    int          rv_cnt = 0;
    int          gnt_dly_cfg = 0;
    int          rv_dly_cfg = 0;
    logic        tx_flushed = 1'b0;
    logic [31:0] tx_pc = '0;
    logic        force_en = 1'b1;
    logic [31:0] force_rdata = '0;
    logic        force_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // PC value the DUT saw at each rising edge.
    always @(posedge clk) pc_at_edge <= pc_i;

    // One clock of stimulus: core PC register, flush, and the memory responder.
    task automatic drive_cycle(input logic f, input logic [31:0] fpc);
        exp_t e;
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        if (adv_flag) begin
            adv_flag = 1'b0;
            pc_i     = pc_i + 32'd4;
        end
        flush = f;
        if (f) pc_i = fpc;
        if (bus_phase == 0 && imem_req === 1'b1) begin
            bus_phase  = 1;
            tx_flushed = 1'b0;
            tx_pc      = pc_at_edge;
            gnt_cnt    = (gnt_dly_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_dly_cfg;
        end
        if (bus_phase != 0 && f) tx_flushed = 1'b1;
        if (bus_phase == 1) begin
            if (gnt_cnt == 0) begin
                imem_gnt  = 1'b1;
                bus_phase = 2;
                rv_cnt    = (rv_dly_cfg < 0) ? int'($urandom_range(0, 3)) : rv_dly_cfg;
            end else begin
                gnt_cnt--;
            end
        end else if (bus_phase == 2) begin
            if (rv_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = force_en ? force_rdata : $urandom;
                imem_err    = force_en ? force_err : ($urandom_range(0, 3) == 0);
                bus_phase   = 0;
                if (!tx_flushed) begin
                    e.instr = imem_rdata;
                    e.pc    = tx_pc;
                    e.err   = imem_err;
                    exp_q.push_back(e);
                end
            end else begin
                rv_cnt--;
            end
        end
    endtask

    task automatic wait_bus_phase(input int ph, input int budget, input string name);
        int n;
        n = 0;
        while (bus_phase != ph && n < budget) begin
            drive_cycle(1'b0, 32'h0);
            n++;
        end
        if (bus_phase != ph) begin
            checks++;
            errors++;
            $display("FAIL %s: bus phase %0d after %0d cycles, expected %0d", name, bus_phase, budget, ph);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            drive_cycle(1'b0, 32'h0);
            n++;
        end
        check_bit(name, instr_valid, 1'b1);
    endtask

    // Monitor: handshake rule, bus address, and scoreboard compare.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check_bit("pc_advance", pc_advance, instr_valid & instr_ready & ~flush);
            if (pc_advance === 1'b1) begin
                adv_count++;
                adv_flag = 1'b1;
            end
            if (imem_req === 1'b1) begin
                if (prev_req !== 1'b1) tx_addr_exp = {pc_at_edge[31:2], 2'b00};
                check("imem_addr", imem_addr, tx_addr_exp);
            end
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got instr 0x%08h pc 0x%08h, expected no instr_valid",
                             instr, instr_pc);
                end else begin
                    check("instr", instr, exp_q[0].instr);
                    check("instr_pc", instr_pc, exp_q[0].pc);
                    check_bit("fetch_err", fetch_err, exp_q[0].err);
                    if (instr_ready === 1'b1 || flush === 1'b1) begin
                        void'(exp_q.pop_front());
                        retired++;
                    end
                end
            end
        end
        prev_req = imem_req;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   a0;
        int   n;
        int   req_cycles;
        logic f;

        rst         = 1'b1;
        pc_i        = 32'h0;
        fetch_en    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        imem_err    = 1'b0;

        // Reset values
        force_en    = 1'b1;
        force_rdata = 32'h0050_0093;
        force_err   = 1'b0;
        gnt_dly_cfg = 0;
        rv_dly_cfg  = 0;
        repeat (2) drive_cycle(1'b0, 32'h0);
        @(negedge clk);
        check_bit("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check_bit("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check_bit("rst_fetch_err", fetch_err, 1'b0);

        // T1: first fetch, gnt immediate, rvalid next cycle -> valid on cycle 4
        drive_cycle(1'b0, 32'h0);
        rst      = 1'b0;
        fetch_en = 1'b1;
        drive_cycle(1'b0, 32'h0);
        check_bit("t1_req_cycle2", imem_req, 1'b1);
        drive_cycle(1'b0, 32'h0);
        check_bit("t1_no_valid_cycle3", instr_valid, 1'b0);
        drive_cycle(1'b0, 32'h0);
        check_bit("t1_valid_cycle4", instr_valid, 1'b1);

        // T3: hold in VALID for 5 cycles, then a single accept pulse
        repeat (5) begin
            drive_cycle(1'b0, 32'h0);
            check_bit("t3_hold_valid", instr_valid, 1'b1);
            check("t3_hold_instr", instr, 32'h0050_0093);
        end
        a0          = adv_count;
        gnt_dly_cfg = 3;
        force_rdata = 32'h0000_8067;
        instr_ready = 1'b1;
        drive_cycle(1'b0, 32'h0);
        check("t3_one_advance", 32'(adv_count - a0), 32'd1);

        // T2: gnt delayed 3 cycles, request held stable at 0x4
        req_cycles = 0;
        n          = 0;
        do begin
            drive_cycle(1'b0, 32'h0);
            if (imem_req === 1'b1) begin
                req_cycles++;
                check("t2_addr_stable", imem_addr, 32'h4);
            end
            n++;
        end while ((req_cycles == 0 || bus_phase != 0) && n < 20);
        check("t2_req_cycles", 32'(req_cycles), 32'd4);
        check("t2_single_advance", 32'(adv_count - a0), 32'd1);

        // T4: flush in WAIT drops the response; next fetch uses 0x100
        gnt_dly_cfg = 0;
        rv_dly_cfg  = 2;
        force_rdata = 32'hDEAD_BEEF;
        wait_bus_phase(2, 20, "t4_wait_gnt");
        drive_cycle(1'b1, 32'h100);
        force_rdata = 32'h1234_5678;
        force_err   = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 12) begin
            check_bit("t4_no_valid", instr_valid, 1'b0);
            drive_cycle(1'b0, 32'h0);
            n++;
        end
        check("t4_new_addr", imem_addr, 32'h100);

        // T5: bus error response, then flush + ready in the same cycle
        instr_ready = 1'b0;
        wait_valid(12, "t5_valid");
        check_bit("t5_fetch_err", fetch_err, 1'b1);
        check("t5_instr_pc", instr_pc, 32'h100);
        fetch_en = 1'b0;
        a0       = adv_count;
        drive_cycle(1'b1, 32'h6);
        instr_ready = 1'b1;
        drive_cycle(1'b0, 32'h0);
        check("t5_no_advance", 32'(adv_count - a0), 32'd0);
        check_bit("t5_flushed", instr_valid, 1'b0);
        force_err = 1'b0;

        // T6: misaligned PC 0x6
        drive_cycle(1'b0, 32'h0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        begin
            exp_t e;
            e.instr = 32'h0000_0013;
            e.pc    = 32'h6;
            e.err   = 1'b1;
            exp_q.push_back(e);
        end
        fetch_en   = 1'b1;
        req_cycles = 0;
        n          = 0;
        while (instr_valid !== 1'b1 && n < 10) begin
            drive_cycle(1'b0, 32'h0);
            if (imem_req === 1'b1) req_cycles++;
            n++;
        end
        fetch_en = 1'b0;
        check("t6_no_req", 32'(req_cycles), 32'd0);
        check_bit("t6_valid", instr_valid, 1'b1);
        check("t6_nop", instr, 32'h0000_0013);
`else
        force_rdata = 32'h00A0_0093;
        fetch_en    = 1'b1;
        n = 0;
        while (imem_req !== 1'b1 && n < 10) begin
            drive_cycle(1'b0, 32'h0);
            n++;
        end
        check("t6_word_addr", imem_addr, 32'h4);
        wait_valid(12, "t6_valid");
        fetch_en = 1'b0;
`endif
        drive_cycle(1'b0, 32'h0);
        drive_cycle(1'b1, 32'h40);

        // T7: reset in WAIT, late rvalid arrives while IDLE
        fetch_en    = 1'b1;
        rv_dly_cfg  = 3;
        force_rdata = 32'hCAFE_0001;
        wait_bus_phase(2, 20, "t7_wait_gnt");
        drive_cycle(1'b0, 32'h0);
        rst        = 1'b1;
        fetch_en   = 1'b0;
        tx_flushed = 1'b1;
        drive_cycle(1'b0, 32'h0);
        rst = 1'b0;
        check_bit("t7_req_after_rst", imem_req, 1'b0);
        check("t7_addr_after_rst", imem_addr, 32'h0);
        repeat (5) begin
            drive_cycle(1'b0, 32'h0);
            check_bit("t7_no_valid", instr_valid, 1'b0);
        end

        // Randomized traffic
        gnt_dly_cfg = -1;
        rv_dly_cfg  = -1;
        force_en    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            f = ($urandom_range(0, 24) == 0);
            drive_cycle(f, {20'h0, 10'($urandom_range(0, 1023)), 2'b00});
            fetch_en    = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
        end

        // Drain
        fetch_en    = 1'b0;
        instr_ready = 1'b1;
        repeat (30) drive_cycle(1'b0, 32'h0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check_bit("traffic_seen", (retired > 50), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch
